// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between IF and MEM stages.
// Ports: if_* fetch side, d_* data side, mem_* memory bus, *_stall freezes.
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req_r,
  input  logic        d_req_w,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} own_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  own_t          last_grant, grant;
  logic          is_write;
  logic          d_req, d_wins, take;

  // last_grant doubles as the owner of the access in flight.
  assign d_req  = d_req_r | d_req_w;
  assign d_wins = d_req & (~if_req | (last_grant == OWN_I));

  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    grant    = d_wins ? OWN_D : OWN_I;
    mem_we   = 1'b0;
    mem_oe   = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req | if_req) begin
          take     = 1'b1;
          state_nx = BUSY;
          cnt_nx   = CNT_LOAD;
        end
      end
      BUSY: begin
        mem_we = is_write;
        mem_oe = ~is_write;
        if (cnt == '0) state_nx = DONE;
        else cnt_nx = cnt - 1'b1;
      end
      DONE: begin
        if_ready = (last_grant == OWN_I);
        d_ready  = (last_grant == OWN_D);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWN_I;
      is_write   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (take) begin
        last_grant <= grant;
        is_write   <= (grant == OWN_D) & d_req_w;
        mem_addr   <= (grant == OWN_D) ? d_addr : if_addr;
        if (grant == OWN_D) mem_wdata <= d_wdata;
      end
      // Read data is valid on the last BUSY edge only.
      if (state == BUSY && cnt == '0 && !is_write) begin
        if (last_grant == OWN_D) d_rdata <= mem_rdata;
        else if_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random + directed bench for mem_arbiter.
// Transaction-level model predicts grants, bus windows and ready pulses.
module tb_mem_arbiter;
  localparam int AC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, d_req_r, d_req_w;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, if_stall, d_ready, d_stall, mem_we, mem_oe;

  logic        s_rst = 1'b0;
  logic        s_if_req;
  logic [31:0] s_if_addr;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic        s_if_ready, s_if_stall, s_d_ready, s_d_stall;
  logic        s_mem_we, s_mem_oe;

  logic [31:0] bus_mem [1024];
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  mem_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_req_r(d_req_r), .d_req_w(d_req_w),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(s_rst),
    .if_req(s_if_req), .if_addr(s_if_addr),
    .if_rdata(s_if_rdata), .if_ready(s_if_ready), .if_stall(s_if_stall),
    .d_req_r(1'b0), .d_req_w(1'b0),
    .d_addr(32'd0), .d_wdata(32'd0),
    .d_rdata(s_d_rdata), .d_ready(s_d_ready), .d_stall(s_d_stall),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_we(s_mem_we), .mem_oe(s_mem_oe), .mem_rdata(s_mem_rdata)
  );

  assign mem_rdata   = bus_mem[mem_addr[11:2]];
  assign s_mem_rdata = bus_mem[s_mem_addr[11:2]];

  always @(posedge clk)
    if (mem_we) bus_mem[mem_addr[11:2]] <= mem_wdata;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state (transaction level).
  int          cyc;
  int          g_start, free_at;
  bit          g_own_d, g_write, last_d;
  logic [31:0] g_rdata, exp_addr, exp_wdata;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  int          mode;
  bit          saw_ir, saw_dr;
  int          if_rdy_cyc, d_rdy_cyc;
  bit          obs[$];

  task automatic model_reset();
    g_start      = -100;
    free_at      = 0;
    last_d       = 1'b0;
    g_own_d      = 1'b0;
    g_write      = 1'b0;
    exp_addr     = '0;
    exp_wdata    = '0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    saw_ir       = 1'b0;
    saw_dr       = 1'b0;
  endtask

  task automatic cycle();
    bit busy, done, ird, drd, dreq;
    busy = cyc > g_start && cyc <= g_start + AC;
    done = cyc == g_start + AC + 1;
    ird  = done && !g_own_d;
    drd  = done && g_own_d;
    dreq = d_req_r || d_req_w;
    if (ird) exp_if_rdata = g_rdata;
    if (drd && !g_write) exp_d_rdata = g_rdata;
    check("if_ready", if_ready, ird);
    check("d_ready", d_ready, drd);
    check("mem_oe", mem_oe, busy && !g_write);
    check("mem_we", mem_we, busy && g_write);
    check("mem_addr", mem_addr, exp_addr);
    if (busy && g_write) check("mem_wdata", mem_wdata, exp_wdata);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    check("if_stall", if_stall, if_req && !ird);
    check("d_stall", d_stall, dreq && !drd);
    if (if_ready) begin if_rdy_cyc = cyc; obs.push_back(1'b0); end
    if (d_ready) begin d_rdy_cyc = cyc; obs.push_back(1'b1); end
    saw_ir = if_ready;
    saw_dr = d_ready;
    if (cyc >= free_at && (if_req || dreq)) begin
      g_own_d  = dreq && (!if_req || !last_d);
      last_d   = g_own_d;
      g_start  = cyc;
      free_at  = cyc + AC + 2;
      g_write  = g_own_d && d_req_w;
      exp_addr = g_own_d ? d_addr : if_addr;
      if (g_write) begin
        exp_wdata = d_wdata;
        ref_mem[exp_addr[11:2]] = d_wdata;
      end else begin
        g_rdata = ref_mem[exp_addr[11:2]];
      end
    end
  endtask

  task automatic stim();
    int op;
    if (saw_ir) if_req = 1'b0;
    if (saw_dr) begin d_req_r = 1'b0; d_req_w = 1'b0; end
    if (mode == 1) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = {20'd0, 1'b1, 9'($urandom), 2'b00};
      end
      if (!d_req_r && !d_req_w && $urandom_range(0, 2) == 0) begin
        op      = $urandom_range(0, 2);
        d_req_r = (op != 1);
        d_req_w = (op != 0);
        d_addr  = {20'd0, 1'b1, 9'($urandom), 2'b00};
        d_wdata = $urandom;
      end
    end else if (mode == 2) begin
      if_req  = 1'b1;
      d_req_r = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      stim();
      #1;
      cycle();
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic clear_inputs();
    if_req  = 1'b0;
    d_req_r = 1'b0;
    d_req_w = 1'b0;
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_oe"}, mem_oe, 1'b0);
    check({tag, "_ir"}, if_ready, 1'b0);
    check({tag, "_dr"}, d_ready, 1'b0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wd"}, mem_wdata, 32'd0);
    check({tag, "_ird"}, if_rdata, 32'd0);
    check({tag, "_drd"}, d_rdata, 32'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    check_rst_outs("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = 32'h1000_0000 + 32'(i * 7);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
    end
    bus_mem[4] = 32'hE3A00001;
    ref_mem[4] = 32'hE3A00001;
    clear_inputs();
    s_if_req  = 1'b0;
    s_if_addr = '0;
    mode = 0;
    cyc  = 0;
    model_reset();

    #2 rst = 1'b1;
    s_rst = 1'b1;
    #1;
    check_rst_outs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // IF read
    if_rdy_cyc = -1;
    t0 = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    run(8);
    check("if_lat", if_rdy_cyc, t0 + 5);

    // data write then read back
    d_rdy_cyc = -1;
    t0 = cyc;
    d_req_w = 1'b1;
    d_addr  = 32'h400;
    d_wdata = 32'hDEADBEEF;
    run(8);
    check("wr_lat", d_rdy_cyc, t0 + 5);
    d_req_r = 1'b1;
    d_addr  = 32'h400;
    run(8);
    check("rd_back", d_rdata, 32'hDEADBEEF);

    // simultaneous after reset: D first
    do_reset();
    if_rdy_cyc = -1;
    d_rdy_cyc  = -1;
    t0 = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req_r = 1'b1;
    d_addr  = 32'h400;
    run(14);
    check("tie_d_lat", d_rdy_cyc, t0 + 5);
    check("tie_i_lat", if_rdy_cyc, t0 + 11);

    // continuous contention: D,I,D,I,D,I
    do_reset();
    obs.delete();
    if_addr = 32'h10;
    d_addr  = 32'h400;
    mode = 2;
    run(36);
    mode = 0;
    clear_inputs();
    run(2);
    check("order_n", obs.size(), 6);
    for (int i = 0; i < obs.size(); i++)
      check("order", obs[i], (i % 2) == 0);

    // reset in 2nd BUSY cycle of a write
    t0 = cyc;
    d_req_w = 1'b1;
    d_addr  = 32'h440;
    d_wdata = $urandom;
    run(2);
    check("mid_we_pre", mem_we, 1'b1);
    rst = 1'b1;
    #1;
    check_rst_outs("mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("held_we", mem_we, 1'b0);
      check("held_oe", mem_oe, 1'b0);
      check("held_dr", d_ready, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_inputs();
    if_rdy_cyc = -1;
    t0 = cyc;
    if_req  = 1'b1;
    if_addr = 32'h10;
    run(8);
    check("post_rst_lat", if_rdy_cyc, t0 + 5);

    // random traffic
    do_reset();
    mode = 1;
    run(3000);
    mode = 0;
    run(30);

    // ACCESS_CYCLES = 1
    @(negedge clk);
    check("s_rst_oe", s_mem_oe, 1'b0);
    s_rst = 1'b0;
    s_if_req  = 1'b1;
    s_if_addr = 32'h10;
    #1;
    check("s_stall_t", s_if_stall, 1'b1);
    check("s_oe_t", s_mem_oe, 1'b0);
    @(negedge clk);
    check("s_oe_t1", s_mem_oe, 1'b1);
    check("s_addr_t1", s_mem_addr, 32'h10);
    check("s_rdy_t1", s_if_ready, 1'b0);
    @(negedge clk);
    check("s_rdy_t2", s_if_ready, 1'b1);
    check("s_data_t2", s_if_rdata, 32'hE3A00001);
    check("s_oe_t2", s_mem_oe, 1'b0);
    check("s_stall_t2", s_if_stall, 1'b0);
    s_if_req = 1'b0;
    @(negedge clk);
    check("s_rdy_t3", s_if_ready, 1'b0);
    check("s_oe_t3", s_mem_oe, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
